time_set_controller: RTL and testbench
======================================

Name: time_set_controller

Overview:
Parametrised successor to the front-panel time/ID control block. Pushbutton edges (not levels) sequence digit-by-digit time entry from a 4-bit switch nibble with per-position clamping in 12 h or 24 h mode, latch a patient ID of configurable width, and run/pause control with a set/load lock. Sits between the switch/button inputs and the timer counter and ROM address path.

Parameters:
NUM_DIGITS, 6, BCD digits entered: 6 = hh mm ss, 4 = hh mm; other values illegal.
MODE_24H, 0, 0 = 12 h limits (max 12:59:59), 1 = 24 h limits (max 23:59:59).
ID_W, 8, patient ID width.

Ports:
clk  in  1  system clock
reset  in  1  synchronous active-high reset
setBtn  in  1  set pushbutton, level
loadBtn  in  1  load-ID pushbutton, level
startBtn  in  1  start pushbutton, level
stopBtn  in  1  stop/pause pushbutton, level
digitIn  in  4  BCD nibble from toggle switches
idIn  in  ID_W  patient ID from toggle switches
timeOut  out  4*NUM_DIGITS  clamped BCD time, most significant digit at top
idOut  out  ID_W  latched patient ID (ROM address)
state  out  3  0 IDLE, 1 SET, 2 LOAD, 3 RUN, 4 PAUSED
digitPtr  out  3  index of next digit to set, 0 = hour tens
running  out  1  high while state == RUN
setDone  out  1  one-cycle pulse when the last digit is written

Behaviour:
- One clock. Reset is synchronous and active-high. Ports are clk and reset.
- Reset values: timeOut 0, idOut 0, state IDLE, digitPtr 0, running 0, setDone 0, button history registers 0.
- Edge detect: each button is registered once. A press is btn & ~btn_q. Holding a button produces exactly one event.
- Latency: a press seen at edge N is applied to all outputs at edge N+1.
- Event priority within a cycle: stop > set > load > start. Only the highest-priority event acts.
- Lock: in RUN, set, load and start are ignored. stop moves to PAUSED, clears running, keeps timeOut and digitPtr.
- In IDLE, SET, LOAD or PAUSED:
  - set writes the clamped digitIn to digit[digitPtr], increments digitPtr, and goes to SET.
  - load latches idIn and goes to LOAD.
  - start goes to RUN and sets running.
  - stop goes to PAUSED.
- Pointer wrap: writing digit NUM_DIGITS-1 returns digitPtr to 0 and pulses setDone for one cycle.
- With no event, state holds. There is no "default" state.
- Clamping: any value above the position limit is replaced by that limit. Positions are 0 hour tens, 1 hour units, 2 minute tens, 3 minute units, 4 second tens, 5 second units.
  - Hour tens: limit 1 in 12 h mode, 2 in 24 h mode.
  - Hour units: limit 9 if hour tens < max. If hour tens == max, limit is 2 in 12 h mode and 3 in 24 h mode.
  - Minute tens and second tens: limit 5.
  - Minute units and second units: limit 9.
- Re-clamp: writing hour tens re-clamps the stored hour units in the same cycle. Example in 12 h mode: units 9 becomes 2 when tens is written as 1.
- 00 hours is legal in both modes.
- Reset mid-entry or mid-run returns everything to its reset values. Partial digits are discarded.

Decomposition:
- Package time_ctrl_pkg holds:
  - state encodings ST_IDLE..ST_PAUSED;
  - digit position constants;
  - limit constants HR_T_MAX_12=1, HR_T_MAX_24=2, HR_U_MAX_12=2, HR_U_MAX_24=3, TENS_MAX=5, UNITS_MAX=9.
- Sub-module bcd_digit_clamp is a combinational block: inputs position, raw nibble, current hour tens and the mode; output is the clamped nibble. It is instanced twice, once for the written digit and once for the hour-units re-clamp.

Test Plan:
- Reset, then six set presses with digitIn 3,9,7,9,8,1 (12 h, 6 digits) -> timeOut 0x125951, setDone pulses once, digitPtr 0.
- MODE_24H=1: set presses with 2 then 7 -> hour 23. Then wrap to hour tens and write 0 -> hour 03, no re-clamp raise.
- Hour units 9 entered with tens 0, then re-enter tens 1 (12 h) -> timeOut hours 12 in the cycle after the press.
- Hold setBtn for 10 cycles -> digitPtr advances by exactly 1. Set and load pressed in the same cycle -> only the digit is written, idOut unchanged.
- start -> state 3, running 1. Then set and load presses -> no change. stop -> state 4, running 0. load with idIn 0xA5 -> idOut 0xA5, state 2.
- reset asserted after 3 digits written -> timeOut 0, digitPtr 0, state 0 on the next edge.

Source files
------------

// File: rtl/time_ctrl_pkg.sv
// Shared encodings and digit limits for the front-panel time/ID controller.
// Imported by the controller and by its digit clamp.
package time_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SET    = 3'd1,
        ST_LOAD   = 3'd2,
        ST_RUN    = 3'd3,
        ST_PAUSED = 3'd4
    } ctrlState_t;

    // Digit positions, 0 is the most significant (hour tens)
    localparam logic [2:0] POS_HR_T  = 3'd0;
    localparam logic [2:0] POS_HR_U  = 3'd1;
    localparam logic [2:0] POS_MIN_T = 3'd2;
    localparam logic [2:0] POS_MIN_U = 3'd3;
    localparam logic [2:0] POS_SEC_T = 3'd4;
    localparam logic [2:0] POS_SEC_U = 3'd5;

    localparam logic [3:0] HR_T_MAX_12 = 4'd1;
    localparam logic [3:0] HR_T_MAX_24 = 4'd2;
    localparam logic [3:0] HR_U_MAX_12 = 4'd2;
    localparam logic [3:0] HR_U_MAX_24 = 4'd3;
    localparam logic [3:0] TENS_MAX    = 4'd5;
    localparam logic [3:0] UNITS_MAX   = 4'd9;

endpackage

// File: rtl/bcd_digit_clamp.sv
// Combinational per-position BCD limiter. The hour-units limit depends on
// the hour-tens value supplied alongside it.
module bcd_digit_clamp
    import time_ctrl_pkg::*;
(
    input  logic [2:0] pos,
    input  logic [3:0] raw,
    input  logic [3:0] hourTens,
    input  logic       mode24,
    output logic [3:0] clamped
);

    logic [3:0] limit;
    logic [3:0] hrTensMax;
    logic [3:0] hrUnitsTop;

    assign hrTensMax  = mode24 ? HR_T_MAX_24 : HR_T_MAX_12;
    assign hrUnitsTop = mode24 ? HR_U_MAX_24 : HR_U_MAX_12;

    always_comb begin
        limit = UNITS_MAX;
        case (pos)
            POS_HR_T:             limit = hrTensMax;
            POS_HR_U:             limit = (hourTens >= hrTensMax) ? hrUnitsTop : UNITS_MAX;
            POS_MIN_T, POS_SEC_T: limit = TENS_MAX;
            default:              limit = UNITS_MAX;
        endcase
        clamped = (raw > limit) ? limit : raw;
    end

endmodule

// File: rtl/time_set_controller.sv
// Edge-driven front-panel controller: digit-by-digit clamped time entry,
// patient ID latch and run/pause sequencing with a lock while running.
module time_set_controller
    import time_ctrl_pkg::*;
#(
    parameter int NUM_DIGITS = 6,
    parameter int MODE_24H   = 0,
    parameter int ID_W       = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    setBtn,
    input  logic                    loadBtn,
    input  logic                    startBtn,
    input  logic                    stopBtn,
    input  logic [3:0]              digitIn,
    input  logic [ID_W-1:0]         idIn,
    output logic [4*NUM_DIGITS-1:0] timeOut,
    output logic [ID_W-1:0]         idOut,
    output logic [2:0]              state,
    output logic [2:0]              digitPtr,
    output logic                    running,
    output logic                    setDone
);

    localparam logic       MODE24   = (MODE_24H != 0);
    localparam logic [2:0] LAST_POS = 3'(NUM_DIGITS - 1);

    ctrlState_t      stateReg, stateNext;
    logic [2:0]      digitPtrReg, digitPtrNext;
    logic [ID_W-1:0] idReg, idNext;
    logic            setDoneReg, setDoneNext;
    logic [3:0]      btnQReg;
    logic [3:0]      btnNow, press;
    logic            writeDigit, reclampUnits;
    logic [3:0]      writeVal, unitsReclamped;
    logic [NUM_DIGITS-1:0][3:0] digitVal;

    // Button order in the history vector: {stop, start, load, set}
    assign btnNow = {stopBtn, startBtn, loadBtn, setBtn};
    assign press  = btnNow & ~btnQReg;

    always_ff @(posedge clk) begin
        if (reset) begin
            btnQReg     <= '0;
            stateReg    <= ST_IDLE;
            digitPtrReg <= '0;
            idReg       <= '0;
            setDoneReg  <= 1'b0;
        end else begin
            btnQReg     <= btnNow;
            stateReg    <= stateNext;
            digitPtrReg <= digitPtrNext;
            idReg       <= idNext;
            setDoneReg  <= setDoneNext;
        end
    end

    always_comb begin
        stateNext    = stateReg;
        digitPtrNext = digitPtrReg;
        idNext       = idReg;
        setDoneNext  = 1'b0;
        writeDigit   = 1'b0;
        if (press[3]) begin
            stateNext = ST_PAUSED;
        end else if (stateReg != ST_RUN) begin
            if (press[0]) begin
                writeDigit   = 1'b1;
                stateNext    = ST_SET;
                digitPtrNext = (digitPtrReg == LAST_POS) ? 3'd0 : digitPtrReg + 3'd1;
                setDoneNext  = (digitPtrReg == LAST_POS);
            end else if (press[1]) begin
                idNext    = idIn;
                stateNext = ST_LOAD;
            end else if (press[2]) begin
                stateNext = ST_RUN;
            end
        end
    end

    // Writing hour tens can lower the hour-units limit, so units are
    // re-limited against the newly written tens in the same cycle.
    assign reclampUnits = writeDigit && (digitPtrReg == POS_HR_T);

    bcd_digit_clamp uWriteClamp (
        .pos      (digitPtrReg),
        .raw      (digitIn),
        .hourTens (digitVal[0]),
        .mode24   (MODE24),
        .clamped  (writeVal)
    );

    bcd_digit_clamp uUnitsClamp (
        .pos      (POS_HR_U),
        .raw      (digitVal[1]),
        .hourTens (writeVal),
        .mode24   (MODE24),
        .clamped  (unitsReclamped)
    );

    generate
        for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
            logic [3:0] digitReg;

            always_ff @(posedge clk) begin
                if (reset) begin
                    digitReg <= '0;
                end else if (writeDigit && (digitPtrReg == 3'(gi))) begin
                    digitReg <= writeVal;
                end else if ((3'(gi) == POS_HR_U) && reclampUnits) begin
                    digitReg <= unitsReclamped;
                end
            end

            assign digitVal[gi] = digitReg;
            assign timeOut[4*(NUM_DIGITS-1-gi) +: 4] = digitReg;
        end
    endgenerate

    assign idOut    = idReg;
    assign state    = stateReg;
    assign digitPtr = digitPtrReg;
    assign running  = (stateReg == ST_RUN);
    assign setDone  = setDoneReg;

endmodule

// File: tb/tb_time_set_controller.sv
// Directed bench: a 12 h / 6-digit and a 24 h / 4-digit controller driven
// by shared front-panel inputs, checked against hand-computed values.
module tb_time_set_controller;

    logic        clk = 1'b0;
    logic        reset;
    logic        setBtn, loadBtn, startBtn, stopBtn;
    logic [3:0]  digitIn;
    logic [7:0]  idIn;

    logic [23:0] t12;
    logic [7:0]  id12;
    logic [2:0]  st12, ptr12;
    logic        run12, done12;

    logic [15:0] t24;
    logic [7:0]  id24;
    logic [2:0]  st24, ptr24;
    logic        run24, done24;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    time_set_controller #(.NUM_DIGITS(6), .MODE_24H(0), .ID_W(8)) dut12 (
        .clk(clk), .reset(reset), .setBtn(setBtn), .loadBtn(loadBtn),
        .startBtn(startBtn), .stopBtn(stopBtn), .digitIn(digitIn), .idIn(idIn),
        .timeOut(t12), .idOut(id12), .state(st12), .digitPtr(ptr12),
        .running(run12), .setDone(done12)
    );

    time_set_controller #(.NUM_DIGITS(4), .MODE_24H(1), .ID_W(8)) dut24 (
        .clk(clk), .reset(reset), .setBtn(setBtn), .loadBtn(loadBtn),
        .startBtn(startBtn), .stopBtn(stopBtn), .digitIn(digitIn), .idIn(idIn),
        .timeOut(t24), .idOut(id24), .state(st24), .digitPtr(ptr24),
        .running(run24), .setDone(done24)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Mask order {stop, start, load, set}; returns at the negedge after the
    // applying clock edge with all buttons released.
    task automatic pressBtns(input logic [3:0] mask);
        @(negedge clk);
        {stopBtn, startBtn, loadBtn, setBtn} = mask;
        @(negedge clk);
        {stopBtn, startBtn, loadBtn, setBtn} = 4'b0000;
        $display("press mask=%b digit=%0d id=%h -> t12=%h st12=%0d ptr12=%0d t24=%h st24=%0d ptr24=%0d",
                 mask, digitIn, idIn, t12, st12, ptr12, t24, st24, ptr24);
    endtask

    task automatic setDigit(input logic [3:0] d);
        digitIn = d;
        pressBtns(4'b0001);
    endtask

    task automatic doReset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        $display("reset pulse");
    endtask

    initial begin
        logic [3:0] digs [6];
        digs = '{4'd3, 4'd9, 4'd7, 4'd9, 4'd8, 4'd1};
        reset = 1'b1;
        {stopBtn, startBtn, loadBtn, setBtn} = 4'b0000;
        digitIn = '0;
        idIn = '0;
        repeat (2) @(negedge clk);
        check("reset_time", 32'(t12), 32'h0);
        check("reset_id", 32'(id12), 32'h0);
        check("reset_state", 32'(st12), 32'd0);
        check("reset_ptr", 32'(ptr12), 32'd0);
        check("reset_running", 32'(run12), 32'd0);
        check("reset_setdone", 32'(done12), 32'd0);
        reset = 1'b0;

        // Full 12 h entry with clamping at every position
        for (int i = 0; i < 6; i++) begin
            setDigit(digs[i]);
            check("entry_setdone", 32'(done12), (i == 5) ? 32'd1 : 32'd0);
        end
        check("entry_time", 32'(t12), 32'h125951);
        check("entry_ptr", 32'(ptr12), 32'd0);
        check("entry_state", 32'(st12), 32'd1);
        @(negedge clk);
        check("setdone_one_cycle", 32'(done12), 32'd0);

        // Held button counts once; set beats load in the same cycle
        doReset();
        digitIn = 4'd0;
        @(negedge clk);
        setBtn = 1'b1;
        repeat (10) @(negedge clk);
        setBtn = 1'b0;
        check("hold_ptr", 32'(ptr12), 32'd1);
        digitIn = 4'd4;
        idIn = 8'h33;
        pressBtns(4'b0011);
        check("setload_time", 32'(t12), 32'h040000);
        check("setload_ptr", 32'(ptr12), 32'd2);
        check("setload_id", 32'(id12), 32'h0);
        check("setload_state", 32'(st12), 32'd1);

        // Run lock, pause, ID load
        pressBtns(4'b0100);
        check("start_state", 32'(st12), 32'd3);
        check("start_running", 32'(run12), 32'd1);
        digitIn = 4'd5;
        idIn = 8'h77;
        pressBtns(4'b0001);
        pressBtns(4'b0010);
        check("lock_time", 32'(t12), 32'h040000);
        check("lock_ptr", 32'(ptr12), 32'd2);
        check("lock_id", 32'(id12), 32'h0);
        check("lock_state", 32'(st12), 32'd3);
        pressBtns(4'b1000);
        check("stop_state", 32'(st12), 32'd4);
        check("stop_running", 32'(run12), 32'd0);
        check("stop_time", 32'(t12), 32'h040000);
        check("stop_ptr", 32'(ptr12), 32'd2);
        idIn = 8'hA5;
        pressBtns(4'b0010);
        check("load_id", 32'(id12), 32'hA5);
        check("load_state", 32'(st12), 32'd2);

        // Hour-units re-clamp when hour tens is rewritten (12 h)
        doReset();
        setDigit(4'd0);
        setDigit(4'd9);
        check("units9_time", 32'(t12), 32'h090000);
        for (int i = 0; i < 4; i++) setDigit(4'd0);
        check("wrap_ptr", 32'(ptr12), 32'd0);
        setDigit(4'd1);
        check("reclamp12_time", 32'(t12), 32'h120000);

        // 24 h / 4-digit instance
        doReset();
        setDigit(4'd2);
        setDigit(4'd7);
        check("h24_23", 32'(t24), 32'h2300);
        setDigit(4'd0);
        setDigit(4'd0);
        check("h24_setdone", 32'(done24), 32'd1);
        check("h24_wrap_ptr", 32'(ptr24), 32'd0);
        setDigit(4'd0);
        check("h24_03", 32'(t24), 32'h0300);
        setDigit(4'd9);
        setDigit(4'd9);
        setDigit(4'd9);
        check("h24_0959", 32'(t24), 32'h0959);
        setDigit(4'd9);
        check("h24_reclamp", 32'(t24), 32'h2359);

        // Reset mid-entry discards partial digits
        doReset();
        setDigit(4'd1);
        setDigit(4'd2);
        setDigit(4'd3);
        check("partial_time", 32'(t12), 32'h123000);
        check("partial_ptr", 32'(ptr12), 32'd3);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("midreset_time", 32'(t12), 32'h0);
        check("midreset_ptr", 32'(ptr12), 32'd0);
        check("midreset_state", 32'(st12), 32'd0);
        reset = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
